sorted_window_median: RTL and testbench

SORTED_WINDOW_MEDIAN -- requirements
Module: sorted_window_median

---
 rtl/sorted_window_median_pkg.sv | 19 +
 rtl/window_cell.sv | 47 ++++
 rtl/sorted_window_median.sv | 105 ++++++++++
 tb/tb_sorted_window_median.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sorted_window_median_pkg.sv
// Shared constants and sizing helpers for the sorted sliding-window median block.
package sorted_window_median_pkg;

  localparam int unsigned DATA_LENGTH = 16;
  localparam int unsigned W           = 300;
  localparam int unsigned MID         = (W - 1) / 2;
  localparam int unsigned CNT_W       = $clog2(W + 1);

  // Median index of an odd-length window.
  function automatic int unsigned mid_of(input int unsigned w);
    return (w - 1) / 2;
  endfunction

  // Width of a counter that saturates at w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/window_cell.sv
// One slot of the sorted window: removes the outgoing sample and inserts the new one
// using only its neighbours' values and the ripple removal/insertion flags.
module window_cell #(
  parameter int unsigned DATA_LENGTH = 16,
  parameter bit          IS_LAST     = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_LENGTH-1:0] in_new,
  input  logic [DATA_LENGTH-1:0] in_old,
  input  logic [DATA_LENGTH-1:0] s_prev,
  input  logic [DATA_LENGTH-1:0] s_next,
  input  logic                   past_prev,
  input  logic                   ins_prev,
  output logic                   eq_c,
  output logic                   past_c,
  output logic                   ins_c,
  output logic [DATA_LENGTH-1:0] s
);

  logic [DATA_LENGTH-1:0] r_cur;
  logic [DATA_LENGTH-1:0] r_prev;
  logic [DATA_LENGTH-1:0] s_nxt;

  // r_* is the window with one in_old removed; the last slot always counts as
  // past the removal point so an absent in_old drops the largest value.
  always_comb begin
    eq_c   = (s == in_old);
    past_c = past_prev | eq_c | IS_LAST;
    r_cur  = s;
    if (past_c && !IS_LAST) r_cur = s_next;
    r_prev = past_prev ? s : s_prev;
    ins_c  = IS_LAST | (r_cur > in_new);
    s_nxt  = r_cur;
    if (ins_c) s_nxt = ins_prev ? r_prev : in_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
    end else if (in_valid) begin
      s <= s_nxt;
    end
  end

endmodule

// File: rtl/sorted_window_median.sv
// Running median over a W-sample window held as a sorted register array.
// Optional MEDIAN_WARMUP_EN: suppress out_valid until the window has seen W samples.
module sorted_window_median #(
  parameter int unsigned DATA_LENGTH = sorted_window_median_pkg::DATA_LENGTH,
  parameter int unsigned W           = sorted_window_median_pkg::W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_LENGTH-1:0] in_new,
  input  logic [DATA_LENGTH-1:0] in_old,
  output logic [DATA_LENGTH-1:0] out_median,
  output logic                   out_valid,
  output logic                   err
);

  import sorted_window_median_pkg::*;

  localparam int unsigned MID_IDX = mid_of(W);

  logic [DATA_LENGTH-1:0] s [W];
  logic                   found_c;
  logic                   valid_gate_c;

  // Cell chain: removal and insertion flags ripple from index 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_cell
    logic                   eq_c;
    logic                   past_c;
    logic                   ins_c;
    logic                   past_prev;
    logic                   ins_prev;
    logic [DATA_LENGTH-1:0] s_prev;
    logic [DATA_LENGTH-1:0] s_next;

    if (i == 0) begin : g_head
      assign s_prev    = '0;
      assign past_prev = 1'b0;
      assign ins_prev  = 1'b0;
    end else begin : g_body
      assign s_prev    = s[i-1];
      assign past_prev = g_cell[i-1].past_c;
      assign ins_prev  = g_cell[i-1].ins_c;
    end

    if (i == W - 1) begin : g_tail
      assign s_next = '0;
    end else begin : g_inner
      assign s_next = s[i+1];
    end

    window_cell #(
      .DATA_LENGTH(DATA_LENGTH),
      .IS_LAST    (i == W - 1)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_new   (in_new),
      .in_old   (in_old),
      .s_prev   (s_prev),
      .s_next   (s_next),
      .past_prev(past_prev),
      .ins_prev (ins_prev),
      .eq_c     (eq_c),
      .past_c   (past_c),
      .ins_c    (ins_c),
      .s        (s[i])
    );
  end

  // The tail cell forces its own removal flag, so look one slot back plus its match.
  assign found_c = g_cell[W-2].past_c | g_cell[W-1].eq_c;

`ifdef MEDIAN_WARMUP_EN
  localparam int unsigned CW = cnt_width(W);

  logic [CW-1:0] warm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (in_valid && (warm_cnt != CW'(W))) begin
      warm_cnt <= warm_cnt + CW'(1);
    end
  end

  assign valid_gate_c = (warm_cnt >= CW'(W - 1));
`else
  assign valid_gate_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid & valid_gate_c;
      if (in_valid && !found_c) err <= 1'b1;
    end
  end

  // The median slot is itself a register, so this is already a registered output.
  assign out_median = s[MID_IDX];

endmodule

// File: tb/tb_sorted_window_median.sv
// Randomized scoreboard bench for sorted_window_median (W=5, 8-bit samples).
module tb_sorted_window_median;

  localparam int unsigned DL   = 8;
  localparam int unsigned WN   = 5;
  localparam int unsigned MIDN = (WN - 1) / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DL-1:0] in_new = '0;
  logic [DL-1:0] in_old = '0;
  logic [DL-1:0] out_median;
  logic          out_valid;
  logic          err;

  always #5 clk = ~clk;

  sorted_window_median #(
    .DATA_LENGTH(DL),
    .W          (WN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_new    (in_new),
    .in_old    (in_old),
    .out_median(out_median),
    .out_valid (out_valid),
    .err       (err)
  );

  typedef struct packed {
    logic          v;
    logic [DL-1:0] med;
    logic          e;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned srt[$];
  int unsigned dline[$];
  int          m_cnt;
  logic        m_err;

  logic          acc_d = 1'b0;
  logic          rst_d = 1'b0;
  logic          mon_en = 1'b0;
  logic [DL-1:0] last_med = '0;
  logic          last_err = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference window: a sorted multiset plus the delay line feeding in_old.
  function automatic void model_reset();
    srt.delete();
    dline.delete();
    for (int i = 0; i < int'(WN); i++) begin
      srt.push_back(0);
      dline.push_back(0);
    end
    m_cnt = 0;
    m_err = 1'b0;
  endfunction

  function automatic int unsigned rand_val();
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 255);
    return $urandom_range(0, 9);
  endfunction

  task automatic apply(input int unsigned nv, input int unsigned ov);
    int   idx;
    int   pos;
    exp_t e;
    idx = -1;
    foreach (srt[i]) if (idx < 0 && srt[i] == ov) idx = i;
    if (idx < 0) begin
      idx   = int'(WN) - 1;
      m_err = 1'b1;
    end
    srt.delete(idx);
    pos = 0;
    foreach (srt[i]) if (srt[i] <= nv) pos++;
    srt.insert(pos, nv);
    if (m_cnt < int'(WN)) m_cnt++;
`ifdef MEDIAN_WARMUP_EN
    e.v = (m_cnt >= int'(WN));
`else
    e.v = 1'b1;
`endif
    e.med = DL'(srt[MIDN]);
    e.e   = m_err;
    sb.push_back(e);
    in_valid = 1'b1;
    in_new   = DL'(nv);
    in_old   = DL'(ov);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic stream(input int unsigned nv);
    int unsigned ov;
    ov = dline.pop_front();
    dline.push_back(nv);
    apply(nv, ov);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_new   = DL'($urandom);
    in_old   = DL'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit with_valid);
    reset    = 1'b1;
    in_valid = with_valid;
    in_new   = DL'($urandom);
    in_old   = DL'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    acc_d <= in_valid & ~reset;
    rst_d <= reset;
  end

  // Monitor: every cycle either a reset result, an accepted-sample result, or a hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst_d) begin
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_median", 32'(out_median), 0);
        chk("reset_err", 32'(err), 0);
        last_med = '0;
        last_err = 1'b0;
      end else if (acc_d) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL scoreboard_empty: sample accepted with no expectation at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("out_valid", 32'(out_valid), 32'(e.v));
          chk("out_median", 32'(out_median), 32'(e.med));
          chk("err", 32'(err), 32'(e.e));
          last_med = e.med;
          last_err = e.e;
        end
      end else begin
        chk("idle_valid", 32'(out_valid), 0);
        chk("hold_median", 32'(out_median), 32'(last_med));
        chk("hold_err", 32'(err), 32'(last_err));
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // Fill from an all-zero window, then slide.
    apply(9, 0); apply(3, 0); apply(7, 0); apply(1, 0); apply(5, 0);
    apply(4, 9); apply(8, 3);
    // Build {5,5,5,2,2} including an old==new step, then drop one duplicate 5.
    apply(5, 7); apply(5, 1); apply(5, 5); apply(2, 4); apply(2, 8);
    apply(2, 5);
    idle(); idle();
    apply(7, 2); apply(7, 7);
    idle();
    // Absent in_old: largest goes, err sticks.
    apply(50, 200); apply(3, 2);
    idle();
    apply(4, 3);

    // Mid-stream reset with a sample presented, then aligned random streaming.
    do_reset(1'b1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) idle();
      stream(rand_val());
      if (k == 200) do_reset(1'($urandom_range(0, 1)));
    end
    repeat (3) idle();
    chk("scoreboard_drain", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
